// File: rtl/int_event_arbiter.sv
// int_event_arbiter
// Round-robin arbiter that collects completion events from up to four
// descriptor-engine channels and pushes them, one at a time, into the
// interrupt controller event FIFO. Also keeps a saturating count of pushes.
//
// Optional build macro: INT_ERR_PRIORITY_EN
//   When defined, requesting channels that report wrError, rdError or
//   invalidDscrptr win over error-free requesters. Round-robin order from
//   rr_ptr applies inside each group.
module int_event_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_CHANNELS-1:0]   evt_valid,
    output logic [NUM_CHANNELS-1:0]   evt_ready,
    input  logic [4*NUM_CHANNELS-1:0] evt_status,
    input  logic [5*NUM_CHANNELS-1:0] evt_dscrptr_num,
    input  logic [NUM_CHANNELS-1:0]   evt_ext,
    input  logic [NUM_CHANNELS-1:0]   evt_str,
    input  logic [32*NUM_CHANNELS-1:0] evt_ext_addr,
    input  logic                      fifo_full,
    output logic                      valid,
    output logic                      opDone,
    output logic                      wrError,
    output logic                      rdError,
    output logic                      invalidDscrptr,
    output logic [4:0]                intDscrptrNum,
    output logic                      extDscrptr,
    output logic                      strDscrptr,
    output logic [31:0]               extDscrptrAddr,
    input  logic                      cnt_clr,
    output logic [CNT_WIDTH-1:0]      evt_cnt
);

    // Registered state
    logic [1:0]           rr_ptr_reg;
    logic                 valid_reg;
    logic [3:0]           status_reg;
    logic [4:0]           num_reg;
    logic                 ext_reg;
    logic                 str_reg;
    logic [31:0]          addr_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Arbitration signals
    logic [3:0] req_pad;
    logic [1:0] chan_at [NUM_CHANNELS];
    logic       grant_en;
    logic       grant_found;
    logic       grant;
    logic [1:0] grant_idx;
    logic [1:0] rr_ptr_next;

    // Selected payload of the granted channel
    logic [3:0]  sel_status;
    logic [4:0]  sel_num;
    logic        sel_ext;
    logic        sel_str;
    logic [31:0] sel_addr;

    // Pad the request vector to four entries so a 2-bit channel index
    // always addresses it cleanly; non-existent channels never request.
    for (genvar gi = 0; gi < 4; gi++) begin : g_req_pad
        if (gi < NUM_CHANNELS) begin : g_real
            assign req_pad[gi] = evt_valid[gi];
        end else begin : g_absent
            assign req_pad[gi] = 1'b0;
        end
    end

`ifdef INT_ERR_PRIORITY_EN
    logic [3:0] err_pad;

    // A channel belongs to the error group if any of its error bits is set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_err_pad
        if (gi < NUM_CHANNELS) begin : g_real
            assign err_pad[gi] = |evt_status[4*gi+1 +: 3];
        end else begin : g_absent
            assign err_pad[gi] = 1'b0;
        end
    end
`endif

    // chan_at[k] is the channel searched at position k: (rr_ptr + k) mod N.
    // Both operands are below N, so a single conditional subtract wraps it.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_search_order
        logic [2:0] pos_sum;
        assign pos_sum     = {1'b0, rr_ptr_reg} + 3'(gi);
        assign chan_at[gi] = (pos_sum >= 3'(NUM_CHANNELS)) ?
                             2'(pos_sum - 3'(NUM_CHANNELS)) : pos_sum[1:0];
    end

    // Grants only while out of reset, FIFO has room and no push is in
    // flight, so fifo_full is always current before the next grant.
    assign grant_en = resetn & ~fifo_full & ~valid_reg;

    // Pick the first requester in search order; scanning from the far end
    // lets the nearest position overwrite later ones.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (req_pad[chan_at[k]]) begin
                grant_found = 1'b1;
                grant_idx   = chan_at[k];
            end
        end
`ifdef INT_ERR_PRIORITY_EN
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (req_pad[chan_at[k]] && err_pad[chan_at[k]]) begin
                grant_found = 1'b1;
                grant_idx   = chan_at[k];
            end
        end
`endif
    end

    assign grant = grant_en & grant_found;

    // One-hot ready toward the granted channel.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ready
        assign evt_ready[gi] = grant & (grant_idx == 2'(gi));
    end

    // Round-robin pointer moves just past the winner.
    assign rr_ptr_next = (grant_idx == 2'(NUM_CHANNELS - 1)) ? 2'd0 : grant_idx + 2'd1;

    // Payload multiplexer for the granted channel.
    always_comb begin
        sel_status = 4'd0;
        sel_num    = 5'd0;
        sel_ext    = 1'b0;
        sel_str    = 1'b0;
        sel_addr   = 32'd0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_status = evt_status[4*i +: 4];
                sel_num    = evt_dscrptr_num[5*i +: 5];
                sel_ext    = evt_ext[i];
                sel_str    = evt_str[i];
                sel_addr   = evt_ext_addr[32*i +: 32];
            end
        end
    end

    // Output register: one-cycle push strobe, payload held between pushes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_reg  <= 1'b0;
            status_reg <= 4'd0;
            num_reg    <= 5'd0;
            ext_reg    <= 1'b0;
            str_reg    <= 1'b0;
            addr_reg   <= 32'd0;
            rr_ptr_reg <= 2'd0;
        end else begin
            valid_reg <= grant;
            if (grant) begin
                status_reg <= sel_status;
                num_reg    <= sel_num;
                ext_reg    <= sel_ext;
                str_reg    <= sel_str;
                addr_reg   <= sel_addr;
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    // Saturating push counter; clear has priority over a concurrent push.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (valid_reg && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign valid          = valid_reg;
    assign opDone         = status_reg[0];
    assign wrError        = status_reg[1];
    assign rdError        = status_reg[2];
    assign invalidDscrptr = status_reg[3];
    assign intDscrptrNum  = num_reg;
    assign extDscrptr     = ext_reg;
    assign strDscrptr     = str_reg;
    assign extDscrptrAddr = addr_reg;
    assign evt_cnt        = cnt_reg;

endmodule

// File: tb/tb_int_event_arbiter.sv
// Testbench for int_event_arbiter: directed stimulus, expected events are
// queued by the stimulus and checked by an independent push monitor.
// The counter is narrowed to 8 bits so saturation is reachable quickly.
module tb_int_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clock;
    logic          resetn;
    logic [N-1:0]  evt_valid;
    logic [N-1:0]  evt_ready;
    logic [4*N-1:0] evt_status;
    logic [5*N-1:0] evt_dscrptr_num;
    logic [N-1:0]  evt_ext;
    logic [N-1:0]  evt_str;
    logic [32*N-1:0] evt_ext_addr;
    logic          fifo_full;
    logic          valid;
    logic          opDone, wrError, rdError, invalidDscrptr;
    logic [4:0]    intDscrptrNum;
    logic          extDscrptr, strDscrptr;
    logic [31:0]   extDscrptrAddr;
    logic          cnt_clr;
    logic [CW-1:0] evt_cnt;

    int checks = 0;
    int errors = 0;
    logic [42:0] exp_q [$];
    logic [42:0] mon_act;
    logic [42:0] mon_exp;
    logic [N-1:0] acc;

    int_event_arbiter #(.NUM_CHANNELS(N), .CNT_WIDTH(CW)) dut (
        .clock(clock), .resetn(resetn),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_status(evt_status), .evt_dscrptr_num(evt_dscrptr_num),
        .evt_ext(evt_ext), .evt_str(evt_str), .evt_ext_addr(evt_ext_addr),
        .fifo_full(fifo_full), .valid(valid),
        .opDone(opDone), .wrError(wrError), .rdError(rdError),
        .invalidDscrptr(invalidDscrptr), .intDscrptrNum(intDscrptrNum),
        .extDscrptr(extDscrptr), .strDscrptr(strDscrptr),
        .extDscrptrAddr(extDscrptrAddr), .cnt_clr(cnt_clr), .evt_cnt(evt_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [42:0] exp_of(input int ch);
        return {evt_status[4*ch +: 4], evt_dscrptr_num[5*ch +: 5],
                evt_ext[ch], evt_str[ch], evt_ext_addr[32*ch +: 32]};
    endfunction

    task automatic set_ch(input int ch, input logic [3:0] st, input logic [4:0] num,
                          input logic ext, input logic str, input logic [31:0] addr);
        evt_status[4*ch +: 4]      = st;
        evt_dscrptr_num[5*ch +: 5] = num;
        evt_ext[ch]                = ext;
        evt_str[ch]                = str;
        evt_ext_addr[32*ch +: 32]  = addr;
    endtask

    // Distinct, error-free payloads so grant order is visible.
    task automatic base_payloads();
        for (int i = 0; i < N; i++)
            set_ch(i, 4'b0001, 5'(4 + i), i[0], i[1], 32'h1000_0000 + 32'(i) * 32'h111);
    endtask

    // Sample the handshake mid-cycle; the source drops an accepted request
    // just after the edge that transferred it.
    task automatic half_neg();
        @(negedge clock);
        acc = evt_valid & evt_ready;
    endtask

    task automatic half_pos();
        @(posedge clock);
        #1;
        evt_valid = evt_valid & ~acc;
        acc = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            half_neg();
            half_pos();
        end
    endtask

    // Push monitor: every valid cycle must match the oldest expected event.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            mon_act = {invalidDscrptr, rdError, wrError, opDone, intDscrptrNum,
                       extDscrptr, strDscrptr, extDscrptrAddr};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL push: unexpected event got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL push: got %h expected %h", mon_act, mon_exp);
                end else begin
                    $display("push num=%0d addr=%h status=%b ext=%b str=%b",
                             intDscrptrNum, extDscrptrAddr,
                             {invalidDscrptr, rdError, wrError, opDone},
                             extDscrptr, strDscrptr);
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        evt_valid = '0;
        fifo_full = 1'b0;
        cnt_clr   = 1'b0;
        acc       = '0;
        evt_status = '0; evt_dscrptr_num = '0; evt_ext = '0; evt_str = '0; evt_ext_addr = '0;
        base_payloads();
        step(2);

        // Reset state, with every channel requesting during reset
        evt_valid = 4'b1111;
        half_neg();
        chk("ready_in_reset", evt_ready, 4'b0000);
        half_pos();
        chk("reset_valid", valid, 0);
        chk("reset_cnt", evt_cnt, 0);
        chk("reset_payload", {opDone, wrError, rdError, invalidDscrptr, intDscrptrNum,
                              extDscrptr, strDscrptr, extDscrptrAddr}, 0);
        resetn = 1'b1;

        // All four request: grants on even cycles 0,1,2,3 in order
        for (int i = 0; i < N; i++) exp_q.push_back(exp_of(i));
        for (int c = 0; c < 8; c++) begin
            half_neg();
            chk($sformatf("rr_ready_c%0d", c), evt_ready,
                (c % 2 == 0) ? (64'd1 << (c / 2)) : 64'd0);
            half_pos();
        end
        chk("cnt_after_rr", evt_cnt, 4);

        // Single channel 2 with both ext and str flags set
        set_ch(2, 4'b0001, 5'd17, 1'b1, 1'b1, 32'hA5A5_0000);
        evt_valid = 4'b0100;
        exp_q.push_back({4'b0001, 5'd17, 1'b1, 1'b1, 32'hA5A5_0000});
        half_neg();
        chk("ch2_ready", evt_ready, 4'b0100);
        half_pos();
        half_neg();
        chk("ch2_valid", valid, 1);
        chk("ch2_num", intDscrptrNum, 17);
        half_pos();
        half_neg();
        chk("ch2_valid_drop", valid, 0);
        half_pos();
        chk("cnt_after_ch2", evt_cnt, 5);

        // FIFO full blocks all grants; rr_ptr now points at channel 3
        fifo_full = 1'b1;
        evt_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            half_neg();
            chk($sformatf("full_ready_c%0d", c), evt_ready, 0);
            chk($sformatf("full_valid_c%0d", c), valid, 0);
            half_pos();
        end
        exp_q.push_back(exp_of(3));
        exp_q.push_back(exp_of(0));
        exp_q.push_back(exp_of(1));
        exp_q.push_back(exp_of(2));
        fifo_full = 1'b0;
        half_neg();
        chk("unfull_ready", evt_ready, 4'b1000);
        half_pos();
        // Full rises while the push is in flight: that push still completes
        fifo_full = 1'b1;
        half_neg();
        chk("midfull_valid", valid, 1);
        chk("midfull_ready", evt_ready, 0);
        half_pos();
        for (int c = 0; c < 3; c++) begin
            half_neg();
            chk($sformatf("midfull_hold_c%0d", c), evt_ready, 0);
            half_pos();
        end
        fifo_full = 1'b0;
        step(6);
        chk("cnt_after_full", evt_cnt, 9);
        chk("full_drained", evt_valid, 0);

        // Move rr_ptr to 0 via a lone channel-3 grant, then contend 0 vs 3
        evt_valid = 4'b1000;
        exp_q.push_back(exp_of(3));
        step(2);
        set_ch(0, 4'b0001, 5'd9, 1'b0, 1'b0, 32'hC0DE_0000);
        set_ch(3, 4'b0010, 5'd30, 1'b1, 1'b0, 32'hC0DE_0003);
        evt_valid = 4'b1001;
`ifdef INT_ERR_PRIORITY_EN
        exp_q.push_back(exp_of(3));
        exp_q.push_back(exp_of(0));
        half_neg();
        chk("prio_first", evt_ready, 4'b1000);
`else
        exp_q.push_back(exp_of(0));
        exp_q.push_back(exp_of(3));
        half_neg();
        chk("prio_first", evt_ready, 4'b0001);
`endif
        half_pos();
        step(3);
        chk("cnt_after_prio", evt_cnt, 12);

        // Counter clear alone, then saturation with identical payloads
        for (int i = 0; i < N; i++) set_ch(i, 4'b0001, 5'd3, 1'b0, 1'b0, 32'h0000_BEEF);
        evt_valid = '0;
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        chk("cnt_clr_alone", evt_cnt, 0);
        for (int i = 0; i < 255; i++) exp_q.push_back(exp_of(0));
        for (int c = 0; c < 510; c++) begin
            evt_valid = 4'b1111;
            half_neg();
            half_pos();
        end
        evt_valid = '0;
        chk("cnt_full_scale", evt_cnt, 255);
        exp_q.push_back(exp_of(0));
        evt_valid = 4'b1111;
        half_neg();
        half_pos();
        evt_valid = '0;
        step(1);
        chk("cnt_saturated", evt_cnt, 255);
        exp_q.push_back(exp_of(0));
        evt_valid = 4'b1111;
        half_neg();
        half_pos();
        evt_valid = '0;
        cnt_clr = 1'b1;
        half_neg();
        chk("clr_push_valid", valid, 1);
        half_pos();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", evt_cnt, 0);

        // Reset asserted in the cycle a grant would happen
        base_payloads();
        evt_valid = 4'b0010;
        exp_q.push_back(exp_of(1));
        step(2);
        chk("cnt_before_rst", evt_cnt, 1);
        evt_valid = 4'b1111;
        resetn = 1'b0;
        half_neg();
        chk("rst_grant_ready", evt_ready, 0);
        half_pos();
        resetn = 1'b1;
        chk("rst_valid", valid, 0);
        chk("rst_cnt", evt_cnt, 0);
        chk("rst_num", intDscrptrNum, 0);
        chk("rst_addr", extDscrptrAddr, 0);
        for (int i = 0; i < N; i++) exp_q.push_back(exp_of(i));
        half_neg();
        chk("rst_valid_next", valid, 0);
        chk("rst_rr_ptr0", evt_ready, 4'b0001);
        half_pos();
        step(7);
        chk("cnt_after_rst", evt_cnt, 4);

        step(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
